// File: rtl/mem_ctrl.sv
// Byte-wide single-port RAM controller shared by instruction fetch and MEM stage.
// Sequences 1/2/4-byte accesses as consecutive byte transfers, little-endian.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [31:0]           if_data,
  output logic                  if_done,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [1:0]            mem_len,
  input  logic [31:0]           mem_wdata,
  output logic [31:0]           mem_rdata,
  output logic                  mem_done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nx;
  logic [2:0]            n_q, cnt, cnt_inc, len_n;
  logic                  port_if;
  logic [31:0]           wdata_q, buf_q, merged;
  logic [7:0]            wbyte;
  logic                  grant_mem, grant_if;

  // A request seen during a done cycle is held off until the following IDLE cycle.
  always_comb begin
    grant_mem = (state == IDLE) && !if_done && !mem_done && mem_req;
    grant_if  = (state == IDLE) && !if_done && !mem_done && !mem_req && if_req;
    cnt_inc   = cnt + 3'd1;
    addr_nx   = addr_q + ADDR_WIDTH'(cnt_inc);
    case (mem_len)
      2'b00:   len_n = 3'd1;
      2'b01:   len_n = 3'd2;
      default: len_n = 3'd4;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (grant_mem)     state_nx = mem_we ? WR : RD;
        else if (grant_if) state_nx = RD;
      end
      RD:      if (cnt == n_q) state_nx = IDLE;
      WR:      if (cnt == n_q - 3'd1) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Byte cnt-1 arrives on ram_din while cnt counts edges since the accept edge.
  always_comb begin
    merged = buf_q;
    case (cnt)
      3'd1:    merged[7:0]   = ram_din;
      3'd2:    merged[15:8]  = ram_din;
      3'd3:    merged[23:16] = ram_din;
      3'd4:    merged[31:24] = ram_din;
      default: ;
    endcase
    case (cnt)
      3'd0:    wbyte = wdata_q[15:8];
      3'd1:    wbyte = wdata_q[23:16];
      3'd2:    wbyte = wdata_q[31:24];
      default: wbyte = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_data   <= '0;
      mem_rdata <= '0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      ram_addr  <= '0;
      ram_wr    <= 1'b0;
      ram_dout  <= '0;
      addr_q    <= '0;
      n_q       <= '0;
      cnt       <= '0;
      port_if   <= 1'b0;
      wdata_q   <= '0;
      buf_q     <= '0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_mem || grant_if) begin
            cnt      <= '0;
            buf_q    <= '0;
            port_if  <= grant_if;
            addr_q   <= grant_mem ? mem_addr : if_addr;
            ram_addr <= grant_mem ? mem_addr : if_addr;
            n_q      <= grant_mem ? len_n : 3'd4;
            wdata_q  <= mem_wdata;
            ram_wr   <= grant_mem && mem_we;
            ram_dout <= (grant_mem && mem_we) ? mem_wdata[7:0] : 8'h00;
          end
        end
        RD: begin
          cnt   <= cnt_inc;
          buf_q <= merged;
          if (cnt_inc < n_q) ram_addr <= addr_nx;
          if (cnt == n_q) begin
            ram_addr <= '0;
            if (port_if) begin
              if_data <= merged;
              if_done <= 1'b1;
            end else begin
              mem_rdata <= merged;
              mem_done  <= 1'b1;
            end
          end
        end
        WR: begin
          cnt <= cnt_inc;
          if (cnt == n_q - 3'd1) begin
            ram_wr   <= 1'b0;
            ram_addr <= '0;
            ram_dout <= '0;
            mem_done <= 1'b1;
          end else begin
            ram_addr <= addr_nx;
            ram_dout <= wbyte;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a registered-read byte RAM model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_len;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic        busy;

  logic [7:0]  ram [256];
  logic        load_en;
  logic [7:0]  load_addr;
  logic [7:0]  load_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
    .busy(busy)
  );

  // RAM indexed by the low address byte; read data valid one cycle after the address.
  always @(posedge clk) begin
    if (load_en)     ram[load_addr] <= load_data;
    else if (ram_wr) ram[ram_addr[7:0]] <= ram_dout;
    ram_din <= ram[ram_addr[7:0]];
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0;
    mem_addr = 0; mem_len = 0; mem_wdata = 0; load_en = 0; load_addr = 0; load_data = 0;
    for (int unsigned i = 0; i < 256; i++) poke(8'(i), 8'h00);
    poke(8'h10, 8'h11); poke(8'h11, 8'h22); poke(8'h12, 8'h33); poke(8'h13, 8'h44);
    poke(8'h21, 8'hF0); poke(8'hFF, 8'h77);
    poke(8'h00, 8'h66);
    checks++;
    if ({if_data, mem_rdata, if_done, mem_done, ram_addr, ram_wr, ram_dout, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got if_data=%h mem_rdata=%h ram_addr=%h busy=%b exp all 0",
               if_data, mem_rdata, ram_addr, busy);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_fetch();
    if_req = 1'b1; if_addr = 32'h10;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k < 5) begin
        checks++;
        if (busy !== 1'b1 || if_done !== 1'b0) begin
          failures++;
          $display("FAIL fetch_busy k=%0d got busy=%b done=%b exp busy=1 done=0", k, busy, if_done);
        end
        checks++;
        if (ram_addr !== 32'h10 + ((k < 3) ? k : 3)) begin
          failures++;
          $display("FAIL fetch_addr k=%0d got %h exp %h", k, ram_addr, 32'h10 + ((k < 3) ? k : 3));
        end
      end else if (k == 5) begin
        checks++;
        if (if_done !== 1'b1 || busy !== 1'b0 || if_data !== 32'h44332211 || ram_addr !== 0) begin
          failures++;
          $display("FAIL fetch_done got done=%b busy=%b data=%h addr=%h exp 1 0 44332211 0",
                   if_done, busy, if_data, ram_addr);
        end
        if_req = 1'b0;
      end else begin
        checks++;
        if (if_done !== 1'b0 || busy !== 1'b0 || if_data !== 32'h44332211) begin
          failures++;
          $display("FAIL fetch_after got done=%b busy=%b data=%h exp 0 0 44332211", if_done, busy, if_data);
        end
      end
    end
  endtask

  task automatic test_byte_read();
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h21;
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      checks++;
      if (mem_done !== (k == 2)) begin
        failures++;
        $display("FAIL byte_done k=%0d got %b exp %b", k, mem_done, (k == 2));
      end
    end
    checks++;
    if (mem_rdata !== 32'h000000F0) begin
      failures++;
      $display("FAIL byte_data got %h exp 000000f0", mem_rdata);
    end
    mem_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word_write();
    logic [31:0] wd;
    wd = 32'hDEADBEEF;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h40; mem_wdata = wd;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4) begin
        checks++;
        if (ram_wr !== 1'b1 || ram_addr !== 32'h40 + k || ram_dout !== wd[8*k +: 8] || mem_done !== 1'b0) begin
          failures++;
          $display("FAIL write_beat k=%0d got wr=%b addr=%h dout=%h done=%b exp 1 %h %h 0",
                   k, ram_wr, ram_addr, ram_dout, mem_done, 32'h40 + k, wd[8*k +: 8]);
        end
      end else begin
        checks++;
        if (mem_done !== 1'b1 || ram_wr !== 1'b0 || busy !== 1'b0) begin
          failures++;
          $display("FAIL write_done got done=%b wr=%b busy=%b exp 1 0 0", mem_done, ram_wr, busy);
        end
        mem_req = 1'b0;
      end
    end
    checks++;
    if (mem_rdata !== 32'h000000F0) begin
      failures++;
      $display("FAIL write_keeps_rdata got %h exp 000000f0", mem_rdata);
    end
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b11; mem_addr = 32'h40;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (mem_done !== (k == 5)) begin
        failures++;
        $display("FAIL readback_done k=%0d got %b exp %b", k, mem_done, (k == 5));
      end
    end
    checks++;
    if (mem_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL readback_data got %h exp deadbeef", mem_rdata);
    end
    mem_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    int mem_cyc;
    int if_cyc;
    mem_cyc = -1; if_cyc = -1;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b01; mem_addr = 32'h8; mem_wdata = 32'h1234A55A;
    if_req = 1'b1; if_addr = 32'h40;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (mem_done === 1'b1 && if_done === 1'b1) begin
        failures++;
        $display("FAIL contention_overlap k=%0d got both done exp one", k);
      end
      if (mem_done === 1'b1) begin mem_cyc = k; mem_req = 1'b0; end
      if (if_done === 1'b1) begin
        if_cyc = k; if_req = 1'b0;
        checks++;
        if (if_data !== 32'hDEADBEEF) begin
          failures++;
          $display("FAIL contention_if_data got %h exp deadbeef", if_data);
        end
      end
    end
    checks++;
    if (mem_cyc !== 2 || if_cyc !== 9) begin
      failures++;
      $display("FAIL contention_order got mem=%0d if=%0d exp mem=2 if=9", mem_cyc, if_cyc);
    end
    checks++;
    if (ram[8] !== 8'h5A || ram[9] !== 8'hA5 || ram[10] !== 8'h00) begin
      failures++;
      $display("FAIL contention_ram got %h %h %h exp 5a a5 00", ram[8], ram[9], ram[10]);
    end
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 32'h10;
    repeat (3) @(negedge clk);
    checks++;
    if (ram_addr !== 32'h12 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre got addr=%h busy=%b exp 12 1", ram_addr, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({if_data, mem_rdata, if_done, mem_done, ram_addr, ram_wr, ram_dout, busy} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got if_data=%h mem_rdata=%h addr=%h busy=%b exp all 0",
               if_data, mem_rdata, ram_addr, busy);
    end
    if_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (if_done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL midreset_quiet k=%0d got done=%b busy=%b exp 0 0", k, if_done, busy);
      end
    end
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h21;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_done !== 1'b1 || mem_rdata !== 32'h000000F0) begin
      failures++;
      $display("FAIL midreset_recover got done=%b data=%h exp 1 000000f0", mem_done, mem_rdata);
    end
    mem_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b01; mem_addr = 32'hFFFFFFFF;
    @(negedge clk);
    checks++;
    if (ram_addr !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL wrap_addr0 got %h exp ffffffff", ram_addr);
    end
    @(negedge clk);
    checks++;
    if (ram_addr !== 32'h00000000) begin
      failures++;
      $display("FAIL wrap_addr1 got %h exp 00000000", ram_addr);
    end
    @(negedge clk);
    checks++;
    if (mem_done !== 1'b0) begin
      failures++;
      $display("FAIL wrap_early got done=%b exp 0", mem_done);
    end
    @(negedge clk);
    checks++;
    if (mem_done !== 1'b1 || mem_rdata !== 32'h00006677) begin
      failures++;
      $display("FAIL wrap_data got done=%b data=%h exp 1 00006677", mem_done, mem_rdata);
    end
    mem_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_word_fetch();
    test_byte_read();
    test_word_write();
    test_contention();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
